if_stage: RTL and testbench



---
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, drives the fetch address, registers IF/ID.
// Latency: the instruction fetched at pc appears on id_inst one edge later; a redirect costs one bubble.
// Backpressure: freeze holds pc and IF/ID. branch_taken overrides freeze and flushes IF/ID.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   freeze              hazard stall; holds pc and IF/ID
//   branch_taken        redirect; loads branch_addr (word aligned) and flushes IF/ID
//   branch_addr[31:0]   redirect target; bits [1:0] are ignored
//   imem_addr[31:0]     fetch address, equal to pc
//   imem_inst[31:0]     instruction returned combinationally for imem_addr
//   id_pc[31:0]         PC+4 of the instruction held in IF/ID
//   id_inst[31:0]       instruction held in IF/ID
//   id_valid            IF/ID holds a real fetched instruction
// Optional build macro IF_PERF_CNT_EN adds fetch_count[31:0] and flush_count[31:0].

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Low target bits are dropped so pc stays word aligned.
  logic [1:0]  unused_branch_lsbs;
  assign unused_branch_lsbs = branch_addr[1:0];

  assign imem_addr = pc;
  // Wraps modulo 2^32: 32'hFFFF_FFFC advances to 0.
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= {RESET_PC[31:2], 2'b00};
      id_pc    <= 32'd0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (branch_taken) begin
      // The instruction being fetched this cycle is on the wrong path; drop it.
      pc       <= {branch_addr[31:2], 2'b00};
      id_pc    <= 32'd0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (!freeze) begin
      pc       <= pc_plus4;
      id_pc    <= pc_plus4;
      id_inst  <= imem_inst;
      id_valid <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'd0;
      flush_count <= 32'd0;
    end else if (branch_taken) begin
      flush_count <= flush_count + 32'd1;
    end else if (!freeze) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table of directed vectors plus a counter sequence.
// Latency: each vector is one clock edge; outputs are sampled 1 time unit after it.
// Backpressure: freeze/branch are driven from the vector table.

module tb_if_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instruction memory model.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem = 32'hE3A0_0014;
      32'h0000_0004: mem = 32'hE3A0_1A01;
      32'h0000_0008: mem = 32'hE3A0_2103;
      default:       mem = 32'hA500_0000 ^ a;
    endcase
  endfunction

  assign imem_inst = mem(imem_addr);

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] ba;
    logic [31:0] e_pc;
    logic [31:0] e_idpc;
    logic [31:0] e_inst;
    logic        e_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic b, input logic [31:0] ba,
                     input logic [31:0] epc, input logic [31:0] eidpc,
                     input logic [31:0] einst, input logic ev);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.ba = ba;
    v.e_pc = epc; v.e_idpc = eidpc; v.e_inst = einst; v.e_vld = ev;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Basic fetch after reset.
    add(1,0,0,0,            32'h0,  32'h0,  NOP,          0);
    add(0,0,0,0,            32'h4,  32'h4,  32'hE3A00014, 1);
    add(0,0,0,0,            32'h8,  32'h8,  32'hE3A01A01, 1);
    add(0,0,0,0,            32'hC,  32'hC,  32'hE3A02103, 1);
    // Freeze for 3 edges at pc=8.
    add(1,0,0,0,            32'h0,  32'h0,  NOP,          0);
    add(0,0,0,0,            32'h4,  32'h4,  32'hE3A00014, 1);
    add(0,0,0,0,            32'h8,  32'h8,  32'hE3A01A01, 1);
    add(0,1,0,0,            32'h8,  32'h8,  32'hE3A01A01, 1);
    add(0,1,0,0,            32'h8,  32'h8,  32'hE3A01A01, 1);
    add(0,1,0,0,            32'h8,  32'h8,  32'hE3A01A01, 1);
    add(0,0,0,0,            32'hC,  32'hC,  32'hE3A02103, 1);
    add(0,0,0,0,            32'h10, 32'h10, mem(32'hC),   1);
    add(0,0,0,0,            32'h14, 32'h14, mem(32'h10),  1);
    // Redirect at pc=20 to 0x93 -> 0x90, one bubble.
    add(0,0,1,32'h93,       32'h90, 32'h0,  NOP,          0);
    add(0,0,0,0,            32'h94, 32'h94, mem(32'h90),  1);
    // Branch + freeze together at pc=16.
    add(1,0,0,0,            32'h0,  32'h0,  NOP,          0);
    add(0,0,0,0,            32'h4,  32'h4,  32'hE3A00014, 1);
    add(0,0,0,0,            32'h8,  32'h8,  32'hE3A01A01, 1);
    add(0,0,0,0,            32'hC,  32'hC,  32'hE3A02103, 1);
    add(0,0,0,0,            32'h10, 32'h10, mem(32'hC),   1);
    add(0,1,1,32'h4,        32'h4,  32'h0,  NOP,          0);
    add(0,0,0,0,            32'h8,  32'h8,  32'hE3A01A01, 1);
    // Run up to pc=40, then reset while frozen.
    for (int a = 12; a <= 40; a += 4)
      add(0,0,0,0, a, a, mem(a - 4), 1);
    add(1,1,0,0,            32'h0,  32'h0,  NOP,          0);
    add(0,0,0,0,            32'h4,  32'h4,  32'hE3A00014, 1);
    // Reset beats a simultaneous branch.
    add(1,0,1,32'h100,      32'h0,  32'h0,  NOP,          0);
    // Redirect to the top word, then wrap to 0.
    add(0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, NOP,   0);
    add(0,0,0,0,            32'h0,  32'h0,  mem(32'hFFFF_FFFC), 1);
    add(0,0,0,0,            32'h4,  32'h4,  32'hE3A00014, 1);
    // Branch to the current pc: refetch after a bubble.
    add(0,0,1,32'h4,        32'h4,  32'h0,  NOP,          0);
    add(0,0,0,0,            32'h8,  32'h8,  32'hE3A01A01, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].frz, vecs[i].br, vecs[i].ba);
      check32("imem_addr", i, imem_addr,       vecs[i].e_pc);
      check32("id_pc",     i, id_pc,           vecs[i].e_idpc);
      check32("id_inst",   i, id_inst,         vecs[i].e_inst);
      check32("id_valid",  i, {31'd0, id_valid}, {31'd0, vecs[i].e_vld});
    end

    // Freeze must hold IF/ID even when the fetched word would differ:
    // pc=8 now; freeze one edge, outputs stay at the word from address 4.
    step(0,1,0,0);
    check32("frz_hold_inst", 900, id_inst, 32'hE3A01A01);
    check32("frz_hold_addr", 900, imem_addr, 32'h8);

`ifdef IF_PERF_CNT_EN
    step(1,0,0,0);
    check32("fetch_cnt_rst", 950, fetch_count, 32'd0);
    check32("flush_cnt_rst", 950, flush_count, 32'd0);
    for (int k = 0; k < 5; k++) step(0,0,0,0);
    step(0,0,1,32'h40);
    step(0,1,0,0);
    step(0,1,0,0);
    step(0,1,0,0);
    step(0,1,1,32'h80);   // branch wins over freeze; counts as flush only
    check32("fetch_count", 951, fetch_count, 32'd5);
    check32("flush_count", 951, flush_count, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
